pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-boundary register for the five-stage MIPS core, replacing the per-stage hand-written F/D, D/E, E/M, M/W registers. It carries a valid bit, PC, branch-delay flag, exception code, Tnew countdown and an opaque control/data payload of configurable width. It adds hold (stall) and exception-code merge, and distinguishes bubble kinds. One instance sits between each pair of adjacent stages; the hazard unit and CP0 drive its control inputs.

## Interface
- PAYLOAD_W, 160: width of the opaque payload (operands, imm, decoded control).
- TNEW_W, 2: width of the Tnew field.
- PC_INIT, 32'h0000_3000: PC loaded on reset.
- EXC_ENTRY, 32'h0000_4180: PC loaded on exception request.
- CNT_W, 32: width of the performance counters (only used with PIPE_PERF_CNT_EN).
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- req  in  1  exception/interrupt request from CP0; flushes the stage.
- flush  in  1  pipeline clear (bubble insertion) from the hazard unit.
- stall  in  1  hold the current contents.
- in_valid  in  1  the upstream slot holds a real instruction.
- in_pc  in  32  upstream PC.
- in_bd  in  1  upstream branch-delay flag.
- in_tnew  in  TNEW_W  upstream Tnew.
- in_exc  in  5  exception code carried from earlier stages (0 = none).
- local_exc  in  5  exception code detected in the upstream stage this cycle.
- in_payload  in  PAYLOAD_W  upstream payload.
- out_valid, out_pc, out_bd, out_tnew, out_exc, out_payload  out  matching widths  registered stage outputs.
- stall_cnt, bubble_cnt, req_cnt  out  CNT_W each  performance counters (present only with PIPE_PERF_CNT_EN).

## Operation
All updates happen at the rising edge of clk. The priority order is reset > req > flush > stall > load.

- **reset low:** out_valid=0, out_pc=PC_INIT, out_bd=0, out_tnew=0, out_exc=0, out_payload=0, and all counters 0.
- **req:** inserts an exception bubble: out_valid=0, out_pc=EXC_ENTRY, out_bd=0, out_tnew=0, out_exc=0, out_payload=0.
- **flush (no req):** inserts a clear bubble: out_valid=0, out_tnew=0, out_exc=0, out_payload=0.
  - out_pc=in_pc and out_bd=in_bd, so CP0 EPC/BD stay correct for a stalled bubble.
- **stall (no req, no flush):** all outputs hold, including out_tnew; no decrement occurs while held.
- **load:** the stage captures the upstream slot.
  - out_valid=in_valid, out_pc=in_pc, out_bd=in_bd, out_payload=in_payload.
  - out_tnew = in_tnew−1, saturating at 0.
  - out_exc = in_exc if in_exc≠0, else local_exc (the earliest exception wins).
- **Load of in_valid=0:** the payload is still captured, but out_tnew=0 and out_exc=0 are forced.
- **flush and stall together:** flush wins.
- **req on the same cycle as reset deasserting:** reset wins for that edge; req acts on the next edge.

## Timing
- One-cycle latency from inputs to outputs; all outputs come directly from flops, with no combinational input-to-output paths.
- Control inputs are sampled only at the edge; there is no handshake and no back-pressure output.
- Tnew arithmetic is TNEW_W bits and unsigned; 0 stays 0.
- Counters saturate at all-ones and do not wrap.

## Configuration
- **PIPE_PERF_CNT_EN defined:** instantiates the three counters. Each advances by one per edge, with reset low taking priority.
  - stall_cnt: on edges where stall takes effect.
  - bubble_cnt: on edges where out_valid becomes 0 through flush, req, or a load of in_valid=0.
  - req_cnt: on edges where req is high.
- **PIPE_PERF_CNT_EN undefined:** the counter ports and logic are absent. Functional behaviour is identical.

## Structure
- **Shared package `pipe_pkg`:**
  - PC_INIT_DEFAULT and EXC_ENTRY_DEFAULT.
  - EXC_W=5 and the exception-code constants.
  - The saturating-decrement function sat_dec.
- **Sub-module:** one, `sat_counter` (CNT_W-wide, enable, synchronous active-low clear). It is instantiated three times under PIPE_PERF_CNT_EN.

## Test plan
- **Reset:** hold reset low for 2 cycles with the inputs randomised, then release → out_pc=32'h3000, every other output 0, counters 0.
- **Load:** load in_valid=1, in_pc=32'h3010, in_tnew=2, in_exc=0, local_exc=5'd4 → the next edge gives out_valid=1, out_pc=32'h3010, out_tnew=1, out_exc=4.
- **Stall:** assert stall for 3 cycles after a load of tnew=1 → the outputs are unchanged for 3 edges and stall_cnt=3.
- **Flush:** flush with in_pc=32'h3024, in_bd=1 → out_valid=0, out_pc=32'h3024, out_bd=1, out_payload=0, and bubble_cnt increments.
- **req beats flush and stall:** assert req together with flush and stall → out_pc=32'h4180, out_bd=0, out_valid=0, req_cnt=1.
- **Exception merge and Tnew floor:** load in_exc=5'd10 with local_exc=5'd4 → out_exc=10; load in_tnew=0 → out_tnew=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-boundary registers: reset/exception
// PCs, exception-code constants and the saturating Tnew decrement.
package pipe_pkg;

  localparam logic [31:0] PC_INIT_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'h0000_4180;

  localparam int EXC_W = 5;

  typedef enum logic [EXC_W-1:0] {
    EXC_NONE    = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Tnew counts down once per stage boundary and never goes below zero.
  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with stall, flush/exception bubbles and exception merge.
// Define PIPE_PERF_CNT_EN to add the stall/bubble/req performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W = 160,
  parameter int          TNEW_W    = 2,
  parameter logic [31:0] PC_INIT   = PC_INIT_DEFAULT,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
  parameter int          CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic                 in_bd,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [EXC_W-1:0]     local_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic                 out_bd,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     req_cnt
`endif
);

  logic [EXC_W-1:0] merged_exc;

  // An exception already carried from an earlier stage outranks a new local one.
  assign merged_exc = (in_exc != EXC_NONE) ? in_exc : local_exc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pc      <= PC_INIT;
      out_bd      <= 1'b0;
      out_tnew    <= '0;
      out_exc     <= '0;
      out_payload <= '0;
    end else if (req) begin
      out_valid   <= 1'b0;
      out_pc      <= EXC_ENTRY;
      out_bd      <= 1'b0;
      out_tnew    <= '0;
      out_exc     <= '0;
      out_payload <= '0;
    end else if (flush) begin
      // PC/BD still follow upstream so EPC is right if this bubble is stalled on.
      out_valid   <= 1'b0;
      out_pc      <= in_pc;
      out_bd      <= in_bd;
      out_tnew    <= '0;
      out_exc     <= '0;
      out_payload <= '0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_pc      <= in_pc;
      out_bd      <= in_bd;
      out_payload <= in_payload;
      out_tnew    <= in_valid ? TNEW_W'(sat_dec(32'(in_tnew))) : '0;
      out_exc     <= in_valid ? merged_exc : '0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_hit;
  logic bubble_hit;

  assign stall_hit  = !req && !flush && stall;
  assign bubble_hit = req || flush || (!stall && !in_valid);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (stall_hit),
    .count   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (bubble_hit),
    .count   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_req_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (req),
    .count   (req_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed cases then random traffic
// against a behavioural model. Counter checks only under PIPE_PERF_CNT_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int PAYLOAD_W = 160;
  localparam int TNEW_W    = 2;
  localparam int CNT_W     = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 req = 1'b0, flush = 1'b0, stall = 1'b0;
  logic                 in_valid = 1'b0, in_bd = 1'b0;
  logic [31:0]          in_pc = '0;
  logic [TNEW_W-1:0]    in_tnew = '0;
  logic [EXC_W-1:0]     in_exc = '0, local_exc = '0;
  logic [PAYLOAD_W-1:0] in_payload = '0;

  logic                 out_valid, out_bd;
  logic [31:0]          out_pc;
  logic [TNEW_W-1:0]    out_tnew;
  logic [EXC_W-1:0]     out_exc;
  logic [PAYLOAD_W-1:0] out_payload;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]     stall_cnt, bubble_cnt, req_cnt;
`endif

  pipe_stage_reg #(
    .PAYLOAD_W (PAYLOAD_W),
    .TNEW_W    (TNEW_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .stall       (stall),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_bd       (in_bd),
    .in_tnew     (in_tnew),
    .in_exc      (in_exc),
    .local_exc   (local_exc),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_bd      (out_bd),
    .out_tnew    (out_tnew),
    .out_exc     (out_exc),
    .out_payload (out_payload)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .req_cnt     (req_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model of the registered slot, plus counters as plain integers.
  bit                   m_valid, m_bd;
  int unsigned          m_pc, m_tnew, m_exc;
  logic [PAYLOAD_W-1:0] m_payload;
  longint unsigned      m_stall, m_bubble, m_req;
  longint unsigned      cnt_max = (64'd1 << CNT_W) - 1;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned bump(input longint unsigned v);
    return (v >= cnt_max) ? v : v + 1;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rand_payload();
    logic [PAYLOAD_W-1:0] p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_valid = 0; m_pc = 32'h0000_3000; m_bd = 0; m_tnew = 0; m_exc = 0; m_payload = '0;
      m_stall = 0; m_bubble = 0; m_req = 0;
    end else if (req) begin
      m_valid = 0; m_pc = 32'h0000_4180; m_bd = 0; m_tnew = 0; m_exc = 0; m_payload = '0;
      m_req = bump(m_req); m_bubble = bump(m_bubble);
    end else if (flush) begin
      m_valid = 0; m_pc = in_pc; m_bd = in_bd; m_tnew = 0; m_exc = 0; m_payload = '0;
      m_bubble = bump(m_bubble);
    end else if (stall) begin
      m_stall = bump(m_stall);
    end else begin
      m_valid = in_valid; m_pc = in_pc; m_bd = in_bd; m_payload = in_payload;
      if (in_valid) begin
        m_tnew = (in_tnew > 0) ? in_tnew - 1 : 0;
        m_exc  = (in_exc != 0) ? in_exc : local_exc;
      end else begin
        m_tnew = 0; m_exc = 0;
        m_bubble = bump(m_bubble);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input bit rst_n, input bit q, input bit f, input bit s,
                               input bit v, input logic [31:0] pc, input bit bd,
                               input int unsigned tn, input int unsigned ex,
                               input int unsigned lex, input logic [PAYLOAD_W-1:0] pay);
    @(negedge clk);
    reset = rst_n; req = q; flush = f; stall = s;
    in_valid = v; in_pc = pc; in_bd = bd; in_tnew = TNEW_W'(tn);
    in_exc = EXC_W'(ex); local_exc = EXC_W'(lex); in_payload = pay;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".valid"},   256'(out_valid),   256'(m_valid));
    checkOutput({tag, ".pc"},      256'(out_pc),      256'(m_pc));
    checkOutput({tag, ".bd"},      256'(out_bd),      256'(m_bd));
    checkOutput({tag, ".tnew"},    256'(out_tnew),    256'(m_tnew));
    checkOutput({tag, ".exc"},     256'(out_exc),     256'(m_exc));
    checkOutput({tag, ".payload"}, 256'(out_payload), 256'(m_payload));
`ifdef PIPE_PERF_CNT_EN
    checkOutput({tag, ".stall_cnt"},  256'(stall_cnt),  256'(m_stall));
    checkOutput({tag, ".bubble_cnt"}, 256'(bubble_cnt), 256'(m_bubble));
    checkOutput({tag, ".req_cnt"},    256'(req_cnt),    256'(m_req));
`endif
  endtask

  task automatic random_cycle(input bit allow_reset);
    bit rst_n;
    rst_n = !(allow_reset && ($urandom_range(0, 49) == 0));
    applyStimulus(rst_n, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom,
                  1'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 0,
                  $urandom_range(0, 31), rand_payload());
  endtask

  initial begin
    // Reset held low for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    1'($urandom), $urandom_range(0, 3), $urandom_range(0, 31),
                    $urandom_range(0, 31), rand_payload());
    end
    check_all("reset");
    checkOutput("reset.pc_const", 256'(out_pc), 256'(32'h3000));

    // Load with a local exception only.
    applyStimulus(1, 0, 0, 0, 1, 32'h3010, 0, 2, 0, 4, rand_payload());
    check_all("load");
    checkOutput("load.pc_const",   256'(out_pc),   256'(32'h3010));
    checkOutput("load.tnew_const", 256'(out_tnew), 256'(1));
    checkOutput("load.exc_const",  256'(out_exc),  256'(4));

    // Three stalled cycles with fresh upstream data that must be ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 1, $urandom, 1, 3, 7, 9, rand_payload());
      check_all("stall");
    end
    checkOutput("stall.tnew_held", 256'(out_tnew), 256'(1));

    // Flush keeps upstream PC/BD.
    applyStimulus(1, 0, 1, 0, 1, 32'h3024, 1, 3, 6, 2, rand_payload());
    check_all("flush");
    checkOutput("flush.pc_const", 256'(out_pc), 256'(32'h3024));

    // req beats flush and stall.
    applyStimulus(1, 1, 1, 1, 1, 32'h3028, 1, 3, 6, 2, rand_payload());
    check_all("req");
    checkOutput("req.pc_const", 256'(out_pc), 256'(32'h4180));

    // Earliest exception wins; Tnew floors at zero.
    applyStimulus(1, 0, 0, 0, 1, 32'h3030, 0, 1, 10, 4, rand_payload());
    check_all("merge");
    checkOutput("merge.exc_const", 256'(out_exc), 256'(10));
    applyStimulus(1, 0, 0, 0, 1, 32'h3034, 0, 0, 0, 0, rand_payload());
    check_all("tnew_floor");

    // Invalid load: payload captured, tnew/exc forced to zero.
    applyStimulus(1, 0, 0, 0, 0, 32'h3038, 1, 3, 12, 5, rand_payload());
    check_all("invalid_load");

    // req during reset is ignored; it acts on the next edge.
    applyStimulus(0, 1, 0, 0, 1, 32'h3040, 1, 2, 0, 0, rand_payload());
    check_all("req_in_reset");
    applyStimulus(1, 1, 0, 0, 1, 32'h3044, 1, 2, 0, 0, rand_payload());
    check_all("req_after_reset");

    for (int i = 0; i < 400; i++) begin
      random_cycle(1);
      check_all("random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
